// File: rtl/uart_rx_if.sv
// uart_rx bus bundle: serial line in, received byte and status strobes out.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data_out,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, CLOCK_DIV+1 cycles per bit, 2-flop input synchroniser.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_rx #(
  parameter int CLOCK_DIV = 104
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam logic [15:0] DIV  = 16'(CLOCK_DIV);
  localparam logic [15:0] HALF = 16'(CLOCK_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s;
  logic        par_err;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], bus.rx};
    count_d = count_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (count_q == HALF) begin
          count_d = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (count_q == DIV) begin
          count_d = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (count_q == DIV) begin
          count_d   = '0;
          par_err_d = ^{shift_q, rx_s};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (count_q == DIV) begin
          count_d = '0;
          if (rx_s) begin
            if (par_err) begin
              ferr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      // Hold off until the line returns high so a break cannot re-trigger.
      S_BREAK: begin
        count_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      count_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      count_q <= count_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
